// File: rtl/pulse_cmd_decoder.sv
// Framed register-write decoder between the UART receiver and the pulse core.
// Address byte + 1/2/4 data bytes (LSB first), atomic commit, ACK/NAK reply.
module pulse_cmd_decoder #(
  parameter int          TIMEOUT_CYC = 1_000_000,
  parameter logic [31:0] DEF_PER     = 32'd200000,
  parameter logic [15:0] DEF_WID     = 16'd30,
  parameter logic [15:0] DEF_DEL     = 16'd200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [15:0] p1wid2,
  output logic [15:0] del2,
  output logic [15:0] p2wid2,
  output logic [15:0] p1st2,
  output logic [15:0] nut_d,
  output logic [7:0]  nut_w,
  output logic [6:0]  pr_att,
  output logic        cp,
  output logic        bl,
  output logic        rxd
);

  localparam int          TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  localparam logic [7:0]  ACK  = 8'h06;
  localparam logic [7:0]  NAK  = 8'h15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_COMMIT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      addr;
  logic [2:0]      cnt;
  logic [1:0]      idx;
  logic [31:0]     shadow;
  logic [TW-1:0]   timer;

  logic            addr_ok;
  logic [2:0]      addr_cnt;
  logic            last_byte;
  logic            timeout;
  logic            rsp_en;
  logic [7:0]      rsp_code;

  // Address decode: legal range 01..0C, byte count per register width.
  always_comb begin
    addr_ok  = (rx_byte >= 8'h01) && (rx_byte <= 8'h0C);
    addr_cnt = 3'd2;
    if (rx_byte == 8'h01)
      addr_cnt = 3'd4;
    else if (rx_byte >= 8'h0A)
      addr_cnt = 3'd1;
    last_byte = ({1'b0, idx} == (cnt - 3'd1));
    timeout   = (timer == TMAX);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic and response requests.
  always_comb begin
    state_nx = state;
    rsp_en   = 1'b0;
    rsp_code = ACK;
    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (addr_ok) begin
            state_nx = S_DATA;
          end else begin
            rsp_en   = 1'b1;
            rsp_code = NAK;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (last_byte)
            state_nx = S_COMMIT;
        end else if (timeout) begin
          rsp_en   = 1'b1;
          rsp_code = NAK;
          state_nx = S_IDLE;
        end
      end
      S_COMMIT: begin
        rsp_en   = 1'b1;
        rsp_code = ACK;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Frame assembly: address latch, shadow shift-in and inter-byte timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr   <= '0;
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      timer  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_valid && addr_ok) begin
            addr   <= rx_byte[3:0];
            cnt    <= addr_cnt;
            idx    <= '0;
            shadow <= '0;
            timer  <= '0;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            shadow[{idx, 3'b000} +: 8] <= rx_byte;
            idx   <= idx + 2'd1;
            timer <= '0;
          end else if (timeout) begin
            shadow <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Register file: whole value lands in one cycle so the core never sees a torn word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per    <= DEF_PER;
      p1wid  <= DEF_WID;
      del    <= DEF_DEL;
      p2wid  <= DEF_WID;
      p1wid2 <= DEF_WID;
      del2   <= DEF_DEL;
      p2wid2 <= DEF_WID;
      p1st2  <= '0;
      nut_d  <= '0;
      nut_w  <= '0;
      pr_att <= '0;
      cp     <= 1'b0;
      bl     <= 1'b0;
    end else if (state == S_COMMIT) begin
      case (addr)
        4'h1: per    <= shadow;
        4'h2: p1wid  <= shadow[15:0];
        4'h3: del    <= shadow[15:0];
        4'h4: p2wid  <= shadow[15:0];
        4'h5: p1wid2 <= shadow[15:0];
        4'h6: del2   <= shadow[15:0];
        4'h7: p2wid2 <= shadow[15:0];
        4'h8: p1st2  <= shadow[15:0];
        4'h9: nut_d  <= shadow[15:0];
        4'hA: nut_w  <= shadow[7:0];
        4'hB: pr_att <= shadow[6:0];
        4'hC: begin
          cp <= shadow[0];
          bl <= shadow[1];
        end
        default: ;
      endcase
    end
  end

  // Commit strobe, coincident with the register update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rxd <= 1'b0;
    else
      rxd <= (state == S_COMMIT);
  end

  // One-deep response buffer: a new code is dropped only if the old one is stuck.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_byte  <= '0;
      tx_valid <= 1'b0;
    end else if (rsp_en && (!tx_valid || tx_ready)) begin
      tx_byte  <= rsp_code;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_cmd_decoder.sv
// Scoreboard bench for pulse_cmd_decoder: directed frames, queued ACK/NAK
// and register snapshots checked by monitors on tx handshake and rxd.
module tb_pulse_cmd_decoder;

  localparam int TO = 40;

  typedef struct packed {
    logic [31:0] per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [15:0] p1wid2;
    logic [15:0] del2;
    logic [15:0] p2wid2;
    logic [15:0] p1st2;
    logic [15:0] nut_d;
    logic [7:0]  nut_w;
    logic [6:0]  pr_att;
    logic        cp;
    logic        bl;
  } regs_t;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, p1wid2, del2, p2wid2, p1st2, nut_d;
  logic [7:0]  nut_w;
  logic [6:0]  pr_att;
  logic        cp, bl, rxd;

  regs_t       dut_r;
  regs_t       exp_r;
  regs_t       reg_q[$];
  logic [7:0]  tx_q[$];
  int          checks;
  int          failures;

  pulse_cmd_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
    .p1wid2(p1wid2), .del2(del2), .p2wid2(p2wid2),
    .p1st2(p1st2), .nut_d(nut_d), .nut_w(nut_w),
    .pr_att(pr_att), .cp(cp), .bl(bl), .rxd(rxd)
  );

  assign dut_r = {per, p1wid, del, p2wid, p1wid2, del2, p2wid2,
                  p1st2, nut_d, nut_w, pr_att, cp, bl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic regs_t def_regs();
    regs_t r;
    r = '0;
    r.per    = 32'd200000;
    r.p1wid  = 16'd30;
    r.del    = 16'd200;
    r.p2wid  = 16'd30;
    r.p1wid2 = 16'd30;
    r.del2   = 16'd200;
    r.p2wid2 = 16'd30;
    return r;
  endfunction

  task automatic check(input string name, input logic [176:0] act,
                       input logic [176:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    idle(3);
  endtask

  task automatic expect_write(input logic [7:0] ack);
    reg_q.push_back(exp_r);
    tx_q.push_back(ack);
  endtask

  // Response monitor: one pop per accepted tx byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected got=%h exp=none", tx_byte);
      end else begin
        e = tx_q.pop_front();
        check("tx_byte", 177'(tx_byte), 177'(e));
      end
    end
  end

  // Commit monitor: every rxd pulse must match the next expected snapshot.
  always @(negedge clk) begin
    regs_t e;
    if (rxd) begin
      if (reg_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rxd_unexpected got=%h exp=none", dut_r);
      end else begin
        e = reg_q.pop_front();
        check("regs_on_rxd", dut_r, e);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    exp_r    = def_regs();

    #23;
    check("reset_regs", dut_r, exp_r);
    check("reset_tx_valid", 177'(tx_valid), 177'(0));
    check("reset_tx_byte", 177'(tx_byte), 177'(0));
    check("reset_rxd", 177'(rxd), 177'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    exp_r.per = 32'h00030D40;
    expect_write(8'h06);
    send_gap(8'h01);
    send_gap(8'h40);
    send_gap(8'h0D);
    send_gap(8'h03);
    send_byte(8'h00);
    @(negedge clk);
    check("lat_per_early", 177'(per), 177'(32'd200000));
    check("lat_rxd_early", 177'(rxd), 177'(0));
    @(negedge clk);
    check("lat_per", 177'(per), 177'(32'h00030D40));
    check("lat_rxd", 177'(rxd), 177'(1));
    idle(6);

    exp_r.p1wid = 16'h1234;
    expect_write(8'h06);
    send_gap(8'h02);
    send_gap(8'h34);
    send_gap(8'h12);
    idle(6);
    check("ack_consumed", 177'(tx_valid), 177'(0));

    tx_q.push_back(8'h15);
    send_gap(8'h01);
    send_gap(8'hAA);
    send_byte(8'hBB);
    idle(TO + 5);
    check("timeout_per", 177'(per), 177'(32'h00030D40));
    check("timeout_tx_idle", 177'(tx_valid), 177'(0));

    exp_r.del = 16'd200;
    expect_write(8'h06);
    send_gap(8'h03);
    send_gap(8'hC8);
    send_gap(8'h00);
    idle(6);

    tx_q.push_back(8'h15);
    send_gap(8'h20);
    idle(4);
    exp_r.cp = 1'b1;
    exp_r.bl = 1'b1;
    expect_write(8'h06);
    send_gap(8'h0C);
    send_gap(8'h03);
    idle(6);
    exp_r.pr_att = 7'h7F;
    expect_write(8'h06);
    send_gap(8'h0B);
    send_gap(8'hFF);
    idle(6);

    tx_ready = 1'b0;
    exp_r.p2wid = 16'hBEEF;
    expect_write(8'h06);
    send_gap(8'h04);
    send_gap(8'hEF);
    send_gap(8'hBE);
    idle(4);
    exp_r.nut_d = 16'h0102;
    reg_q.push_back(exp_r);
    send_gap(8'h09);
    send_gap(8'h02);
    send_gap(8'h01);
    idle(4);
    check("held_tx_valid", 177'(tx_valid), 177'(1));
    check("held_tx_byte", 177'(tx_byte), 177'(8'h06));
    tx_ready = 1'b1;
    idle(4);
    check("single_accept", 177'(tx_valid), 177'(0));

    send_gap(8'h01);
    send_byte(8'h11);
    #2;
    reset = 1'b1;
    #1;
    exp_r = def_regs();
    check("async_reset_regs", dut_r, exp_r);
    check("async_reset_tx", 177'(tx_valid), 177'(0));
    idle(2);
    reset = 1'b0;
    idle(2);

    exp_r.nut_w = 8'h55;
    expect_write(8'h06);
    send_gap(8'h0A);
    send_gap(8'h55);
    idle(6);
    check("final_regs", dut_r, exp_r);

    check("tx_q_drained", 177'(tx_q.size()), 177'(0));
    check("reg_q_drained", 177'(reg_q.size()), 177'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
